// File: rtl/arb_pkg.sv
// Shared definitions for the two-port req/gnt arbiter and its requester agents.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        OWN  = 2'd2,
        REL  = 2'd3
    } arb_state_t;

    localparam int DEFAULT_DATA_W  = 8;
    localparam int DEFAULT_LEN_W   = 4;
    localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/arb_req_timer.sv
// Grant-wait counter: counts ungranted REQ cycles and flags the last allowed one.
module arb_req_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/arb_requester.sv
// Requester agent for one arbiter port: accepts a job, requests the bus and
// streams incrementing beats while granted, re-requesting after preemption.
module arb_requester
    import arb_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int LEN_W   = DEFAULT_LEN_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [LEN_W-1:0]  job_len,
    input  logic [DATA_W-1:0] job_base,
    output logic              req,
    input  logic              gnt,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic              done,
    output logic              timeout_err
);

    arb_state_t        state, state_next;
    logic [LEN_W-1:0]  remaining;
    logic [DATA_W-1:0] next_beat;
    logic              abort;
    logic              timer_clear;
    logic              timer_enable;
    logic              timer_tc;

    arb_req_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .enable   (timer_enable),
        .terminal (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= '0;
            next_beat <= '0;
            abort     <= 1'b0;
        end else begin
            state <= state_next;
            // Only the REQ->REL edge marks an abort; it then holds through REL.
            abort <= (state == REQ) && (state_next == REL);
            if (state == IDLE && job_valid) begin
                remaining <= job_len;
                next_beat <= job_base;
            end else if (state == OWN && gnt) begin
                remaining <= remaining - LEN_W'(1);
                next_beat <= next_beat + DATA_W'(1);
            end
        end
    end

    always_comb begin
        state_next   = state;
        timer_clear  = 1'b1;
        timer_enable = 1'b0;
        unique case (state)
            IDLE: begin
                if (job_valid) begin
                    state_next = (job_len == '0) ? REL : REQ;
                end
            end
            REQ: begin
                timer_clear = 1'b0;
                if (gnt) begin
                    state_next = OWN;
                end else if (timer_tc) begin
                    state_next = REL;
                end else begin
                    timer_enable = 1'b1;
                end
            end
            OWN: begin
                if (!gnt) begin
                    state_next = REQ;
                end else if (remaining == LEN_W'(1)) begin
                    state_next = REL;
                end
            end
            REL: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign req         = (state == REQ) || (state == OWN);
    assign job_ready   = (state == IDLE);
    assign done        = (state == REL) && !abort;
    assign timeout_err = (state == REL) && abort;
    assign bus_valid   = (state == OWN) && gnt;
    assign bus_data    = next_beat;

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: reset, bursts, preemption, timeout, zero length,
// and two agents sharing a small sticky arbiter.
module tb_arb_requester;

    logic       clk = 1'b0;
    logic       rst;
    logic       job_valid;
    logic       job_ready;
    logic [3:0] job_len;
    logic [7:0] job_base;
    logic       req;
    logic       gnt;
    logic       bus_valid;
    logic [7:0] bus_data;
    logic       done;
    logic       timeout_err;

    logic       a_job_valid, b_job_valid;
    logic       a_job_ready, b_job_ready;
    logic [3:0] a_job_len, b_job_len;
    logic [7:0] a_job_base, b_job_base;
    logic       a_req, b_req, a_gnt, b_gnt;
    logic       a_bus_valid, b_bus_valid;
    logic [7:0] a_bus_data, b_bus_data;
    logic       a_done, b_done, a_terr, b_terr;
    logic       owner;

    int checks   = 0;
    int failures = 0;
    int a_beats  = 0;
    int b_beats  = 0;
    int a_dones  = 0;
    int b_dones  = 0;
    int overlaps = 0;
    int data_errs = 0;
    int terrs    = 0;
    logic done_seen;
    logic req_seen;

    always #5 clk = ~clk;

    arb_requester dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
        .job_len(job_len), .job_base(job_base), .req(req), .gnt(gnt),
        .bus_valid(bus_valid), .bus_data(bus_data), .done(done), .timeout_err(timeout_err)
    );

    arb_requester agent_a (
        .clk(clk), .rst(rst), .job_valid(a_job_valid), .job_ready(a_job_ready),
        .job_len(a_job_len), .job_base(a_job_base), .req(a_req), .gnt(a_gnt),
        .bus_valid(a_bus_valid), .bus_data(a_bus_data), .done(a_done), .timeout_err(a_terr)
    );

    arb_requester agent_b (
        .clk(clk), .rst(rst), .job_valid(b_job_valid), .job_ready(b_job_ready),
        .job_len(b_job_len), .job_base(b_job_base), .req(b_req), .gnt(b_gnt),
        .bus_valid(b_bus_valid), .bus_data(b_bus_data), .done(b_done), .timeout_err(b_terr)
    );

    // Sticky two-port arbiter: ownership passes only when the owner drops req.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner <= 1'b0;
        end else if (owner == 1'b0 && !a_req && b_req) begin
            owner <= 1'b1;
        end else if (owner == 1'b1 && !b_req && a_req) begin
            owner <= 1'b0;
        end
    end

    assign a_gnt = a_req && (owner == 1'b0);
    assign b_gnt = b_req && (owner == 1'b1);

    always @(negedge clk) begin
        if (a_bus_valid) begin
            if (a_bus_data !== 8'h50 + 8'(a_beats)) data_errs++;
            a_beats++;
        end
        if (b_bus_valid) begin
            if (b_bus_data !== 8'h60 + 8'(b_beats)) data_errs++;
            b_beats++;
        end
        if (a_bus_valid && b_bus_valid) overlaps++;
        if (a_done) a_dones++;
        if (b_done) b_dones++;
        if (a_terr || b_terr) terrs++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] l, input logic [7:0] b,
                                 input logic g);
        job_valid = v;
        job_len   = l;
        job_base  = b;
        gnt       = g;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        a_job_valid = 1'b0; b_job_valid = 1'b0;
        a_job_len = 4'd0;   b_job_len = 4'd0;
        a_job_base = 8'h00; b_job_base = 8'h00;
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0);
        tick;
        tick;
        checkOutput("rst_req", req, 0);
        checkOutput("rst_job_ready", job_ready, 1);
        checkOutput("rst_bus_valid", bus_valid, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_timeout", timeout_err, 0);
        checkOutput("rst_bus_data", bus_data, 0);
        rst = 1'b1;
        tick;

        // Uninterrupted burst with data wrap
        applyStimulus(1'b1, 4'd3, 8'hFE, 1'b1);
        checkOutput("burst_ready", job_ready, 1);
        tick;
        applyStimulus(1'b0, 4'd3, 8'hFE, 1'b1);
        checkOutput("burst_req", req, 1);
        checkOutput("burst_busy", job_ready, 0);
        checkOutput("burst_no_beat_in_req", bus_valid, 0);
        tick;
        checkOutput("burst_b0_valid", bus_valid, 1);
        checkOutput("burst_b0_data", bus_data, 8'hFE);
        tick;
        checkOutput("burst_b1_valid", bus_valid, 1);
        checkOutput("burst_b1_data", bus_data, 8'hFF);
        tick;
        checkOutput("burst_b2_valid", bus_valid, 1);
        checkOutput("burst_b2_data", bus_data, 8'h00);
        tick;
        checkOutput("burst_rel_req", req, 0);
        checkOutput("burst_rel_done", done, 1);
        checkOutput("burst_rel_valid", bus_valid, 0);
        checkOutput("burst_rel_ready", job_ready, 0);
        tick;
        checkOutput("burst_idle_done", done, 0);
        checkOutput("burst_idle_ready", job_ready, 1);
        checkOutput("idle_gnt_ignored", bus_valid, 0);
        checkOutput("idle_req", req, 0);

        // Preemption in the middle of a 4-beat burst
        applyStimulus(1'b1, 4'd4, 8'd10, 1'b1);
        tick;
        applyStimulus(1'b0, 4'd4, 8'd10, 1'b1);
        checkOutput("pre_req", req, 1);
        tick;
        checkOutput("pre_b0_data", bus_data, 8'd10);
        checkOutput("pre_b0_valid", bus_valid, 1);
        tick;
        checkOutput("pre_b1_data", bus_data, 8'd11);
        checkOutput("pre_b1_valid", bus_valid, 1);
        tick;
        applyStimulus(1'b0, 4'd4, 8'd10, 1'b0);
        checkOutput("pre_lost_valid", bus_valid, 0);
        checkOutput("pre_lost_req", req, 1);
        tick;
        checkOutput("pre_wait_req", req, 1);
        checkOutput("pre_wait_valid", bus_valid, 0);
        tick;
        applyStimulus(1'b0, 4'd4, 8'd10, 1'b1);
        checkOutput("pre_regnt_req", req, 1);
        checkOutput("pre_regnt_valid", bus_valid, 0);
        tick;
        checkOutput("pre_b2_data", bus_data, 8'd12);
        checkOutput("pre_b2_valid", bus_valid, 1);
        tick;
        checkOutput("pre_b3_data", bus_data, 8'd13);
        checkOutput("pre_b3_valid", bus_valid, 1);
        tick;
        checkOutput("pre_rel_done", done, 1);
        checkOutput("pre_rel_req", req, 0);
        tick;
        checkOutput("pre_idle_done", done, 0);
        checkOutput("pre_idle_ready", job_ready, 1);

        // Grant timeout: req must stay up for exactly 16 cycles
        applyStimulus(1'b1, 4'd5, 8'h40, 1'b0);
        tick;
        applyStimulus(1'b0, 4'd5, 8'h40, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("to_req_%0d", i), req, 1);
            checkOutput($sformatf("to_valid_%0d", i), bus_valid, 0);
            tick;
        end
        checkOutput("to_rel_req", req, 0);
        checkOutput("to_rel_err", timeout_err, 1);
        checkOutput("to_rel_done", done, 0);
        tick;
        checkOutput("to_idle_err", timeout_err, 0);
        checkOutput("to_idle_ready", job_ready, 1);

        // Zero-length job completes without requesting
        applyStimulus(1'b1, 4'd0, 8'h00, 1'b0);
        tick;
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0);
        checkOutput("zero_req", req, 0);
        checkOutput("zero_done", done, 1);
        checkOutput("zero_ready", job_ready, 0);
        tick;
        checkOutput("zero_idle_done", done, 0);
        checkOutput("zero_idle_ready", job_ready, 1);
        checkOutput("zero_idle_req", req, 0);

        // Reset while owning the bus abandons the job silently
        applyStimulus(1'b1, 4'd8, 8'h20, 1'b1);
        tick;
        applyStimulus(1'b0, 4'd8, 8'h20, 1'b1);
        tick;
        checkOutput("mid_b0_data", bus_data, 8'h20);
        tick;
        checkOutput("mid_b1_data", bus_data, 8'h21);
        rst = 1'b0;
        tick;
        checkOutput("mid_rst_req", req, 0);
        checkOutput("mid_rst_valid", bus_valid, 0);
        checkOutput("mid_rst_done", done, 0);
        checkOutput("mid_rst_ready", job_ready, 1);
        checkOutput("mid_rst_data", bus_data, 0);
        tick;
        rst = 1'b1;
        done_seen = 1'b0;
        req_seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            done_seen = done_seen | done;
            req_seen  = req_seen | req;
        end
        checkOutput("mid_no_done", done_seen, 0);
        checkOutput("mid_no_req", req_seen, 0);

        // Two agents competing for the shared arbiter
        a_job_valid = 1'b1; a_job_len = 4'd2; a_job_base = 8'h50;
        b_job_valid = 1'b1; b_job_len = 4'd2; b_job_base = 8'h60;
        tick;
        a_job_valid = 1'b0;
        b_job_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
        end
        checkOutput("arb_a_beats", a_beats, 2);
        checkOutput("arb_b_beats", b_beats, 2);
        checkOutput("arb_overlap", overlaps, 0);
        checkOutput("arb_data", data_errs, 0);
        checkOutput("arb_a_done", a_dones, 1);
        checkOutput("arb_b_done", b_dones, 1);
        checkOutput("arb_timeouts", terrs, 0);
        checkOutput("arb_a_ready", a_job_ready, 1);
        checkOutput("arb_b_ready", b_job_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
